// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the core's memory stage and the data-memory
// responder.
//   master : core side   - drives mem_read, mem_write, addr, wdata, func3;
//                          observes ready, busy, valid, rdata, err
//   slave  : memory side - the opposite directions
// Signals:
//   mem_read / mem_write : load / store strobes
//   addr  [31:0]         : byte address
//   wdata [31:0]         : store data (low byte/half used for sb/sh)
//   func3 [2:0]          : access size (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   ready                : responder idle, a strobe this cycle is accepted
//   busy                 : request outstanding
//   valid                : one-cycle response pulse
//   rdata [31:0]         : extended load data
//   err                  : with valid, the access was illegal and had no effect
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output mem_read, mem_write, addr, wdata, func3,
        input  ready, busy, valid, rdata, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata, func3,
        output ready, busy, valid, rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Word-organised data memory serving byte/half/word loads and stores with a
// fixed latency and a ready/valid handshake.
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   LATENCY     : cycles from acceptance to the valid pulse (1..15)
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset (array contents are kept)
//   bus  : dmem_responder_if.slave request/response bundle
//   rd_count / wr_count [15:0] : good load / store counters, present only
//                                when DMEM_ACCESS_CNT_EN is defined
// Optional feature macro: DMEM_ACCESS_CNT_EN
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Illegal-access detection, evaluated on the raw request at acceptance.
    function automatic logic req_illegal(input logic rd, input logic wr,
                                         input logic [1:0] lane, input logic [2:0] f3);
        logic bad;
        bad = 1'b0;
        if (rd && wr) begin
            bad = 1'b1;
        end else begin
            case (f3)
                3'b000:  bad = 1'b0;
                3'b001:  bad = lane[0];
                3'b010:  bad = (lane != 2'b00);
                3'b100:  bad = wr;                 // no unsigned stores
                3'b101:  bad = wr | lane[0];
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    // Byte-lane write enables for a store of the given size at the given lane.
    function automatic logic [3:0] lane_enables(input logic [1:0] lane, input logic [2:0] f3);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Select and extend the addressed lane(s) of a stored word.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0] lane, input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t          state_r, state_s;
    logic [3:0]      cnt_r, cnt_s;
    logic [AW+1:0]   addr_r;
    logic [31:0]     wdata_r;
    logic [2:0]      func3_r;
    logic            is_write_r;
    logic            err_r;
    logic [31:0]     rdata_hold_r;
    logic [31:0]     mem_r [DEPTH_WORDS];

    logic            accept_s;
    logic            ready_s, busy_s, valid_s;
    logic [AW-1:0]   idx_s;
    logic [31:0]     word_s;
    logic [31:0]     resp_data_s;
    logic [31:0]     wdata_lanes_s;
    logic [3:0]      be_s;
    logic            commit_s;
    logic            good_load_s;
    logic            addr_unused_s;

    // Upper address bits alias onto the array and are deliberately ignored.
    assign addr_unused_s = ^bus.addr[31:AW+2];

    assign accept_s = (state_r == ST_IDLE) && (bus.mem_read || bus.mem_write);
    assign idx_s    = addr_r[AW+1:2];
    assign word_s   = mem_r[idx_s];

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (LATENCY == 1) begin
                        state_s = ST_RESP;
                        cnt_s   = 4'd0;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // LATENCY-1 wait cycles: leave when the counter reaches 1.
                if (cnt_r <= 4'd1) begin
                    state_s = ST_RESP;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        ready_s = 1'b0;
        busy_s  = 1'b1;
        valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
                busy_s  = 1'b0;
            end
            ST_WAIT: begin
                ready_s = 1'b0;
            end
            ST_RESP: begin
                valid_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Request capture at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r     <= '0;
            wdata_r    <= 32'h0000_0000;
            func3_r    <= 3'b000;
            is_write_r <= 1'b0;
            err_r      <= 1'b0;
        end else if (accept_s) begin
            addr_r     <= bus.addr[AW+1:0];
            wdata_r    <= bus.wdata;
            func3_r    <= bus.func3;
            is_write_r <= bus.mem_write;
            err_r      <= req_illegal(bus.mem_read, bus.mem_write, bus.addr[1:0], bus.func3);
        end
    end

    assign commit_s    = valid_s && is_write_r && !err_r;
    assign good_load_s = valid_s && !is_write_r && !err_r;
    assign be_s        = lane_enables(addr_r[1:0], func3_r);

    // Replicate the low byte/half so every enabled lane sees the right data.
    always_comb begin
        case (func3_r[1:0])
            2'b00:   wdata_lanes_s = {4{wdata_r[7:0]}};
            2'b01:   wdata_lanes_s = {2{wdata_r[15:0]}};
            default: wdata_lanes_s = wdata_r;
        endcase
    end

    // Array write at the response edge; a reset on that edge aborts the store.
    always_ff @(posedge clk) begin
        if (commit_s && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][i*8 +: 8] <= wdata_lanes_s[i*8 +: 8];
                end
            end
        end
    end

    // Load data is only non-zero for a good load in the response cycle.
    always_comb begin
        if (good_load_s) begin
            resp_data_s = load_extend(word_s, addr_r[1:0], func3_r);
        end else begin
            resp_data_s = 32'h0000_0000;
        end
    end

    // Keep the last good load visible between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_hold_r <= 32'h0000_0000;
        end else if (good_load_s) begin
            rdata_hold_r <= resp_data_s;
        end
    end

    assign bus.ready = ready_s;
    assign bus.busy  = busy_s;
    assign bus.valid = valid_s;
    assign bus.err   = valid_s & err_r;
    assign bus.rdata = valid_s ? resp_data_s : rdata_hold_r;

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_count_r, wr_count_r;

    // Good-access counters, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_r <= 16'h0000;
            wr_count_r <= 16'h0000;
        end else begin
            if (good_load_s) begin
                rd_count_r <= rd_count_r + 16'h0001;
            end
            if (commit_s) begin
                wr_count_r <= wr_count_r + 16'h0001;
            end
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    dmem_responder_if bus();

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef DMEM_ACCESS_CNT_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every valid pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=valid required=no_response");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_err"}, {31'd0, bus.err}, {31'd0, e.err});
                chk({e.name, "_rdata"}, bus.rdata, e.data);
            end
        end
    end

    // Wait (on falling edges) until the responder is idle, bounded.
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=%b required=1", bus.ready);
        end
    endtask

    // Present one request for one cycle; returns #1 after the accepting edge.
    task automatic issue(input string name, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                         input bit push, input logic e, input logic [31:0] x);
        exp_t ex;
        wait_ready();
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.addr      = a;
        bus.wdata     = d;
        bus.func3     = f;
        if (push) begin
            ex.name = name;
            ex.err  = e;
            ex.data = x;
            exp_q.push_back(ex);
        end
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic load(input string name, input logic [31:0] a, input logic [2:0] f,
                        input logic e, input logic [31:0] x);
        issue(name, 1'b1, 1'b0, a, 32'h0, f, 1'b1, e, x);
    endtask

    task automatic store(input string name, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic e);
        issue(name, 1'b0, 1'b1, a, d, f, 1'b1, e, 32'h0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;
        bus.func3     = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_busy",  {31'd0, bus.busy},  32'd0);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_err",   {31'd0, bus.err},   32'd0);

        // sw with handshake timing: accepted at T, response at T+2.
        store("sw_10", 32'h10, 32'hDEADBEEF, 3'b010, 1'b0);
        @(negedge clk);
        chk("t1_ready", {31'd0, bus.ready}, 32'd0);
        chk("t1_busy",  {31'd0, bus.busy},  32'd1);
        chk("t1_valid", {31'd0, bus.valid}, 32'd0);
        @(negedge clk);
        chk("t2_ready", {31'd0, bus.ready}, 32'd0);
        chk("t2_valid", {31'd0, bus.valid}, 32'd1);
        @(negedge clk);
        chk("t3_ready", {31'd0, bus.ready}, 32'd1);
        chk("t3_valid", {31'd0, bus.valid}, 32'd0);
        load("lw_10", 32'h10, 3'b010, 1'b0, 32'hDEADBEEF);

        // Byte store into a known word, then lane/extension reads.
        store("sw_10b", 32'h10, 32'h11223344, 3'b010, 1'b0);
        store("sb_13", 32'h13, 32'h00000080, 3'b000, 1'b0);
        load("lw_10b",  32'h10, 3'b010, 1'b0, 32'h80223344);
        load("lb_13",   32'h13, 3'b000, 1'b0, 32'hFFFFFF80);
        load("lbu_13",  32'h13, 3'b100, 1'b0, 32'h00000080);
        load("lh_12",   32'h12, 3'b001, 1'b0, 32'hFFFF8022);
        load("lhu_10",  32'h10, 3'b101, 1'b0, 32'h00003344);
        load("lb_10",   32'h10, 3'b000, 1'b0, 32'h00000044);

        // Illegal accesses: no effect, err=1, rdata=0.
        load("lh_11_mis", 32'h11, 3'b001, 1'b1, 32'h0);
        store("sw_12_mis", 32'h12, 32'h12345678, 3'b010, 1'b1);
        store("sbu_bad", 32'h10, 32'hFFFFFFFF, 3'b100, 1'b1);
        load("ld_f3_011", 32'h10, 3'b011, 1'b1, 32'h0);
        issue("rd_wr_both", 1'b1, 1'b1, 32'h10, 32'h0, 3'b010, 1'b1, 1'b1, 32'h0);
        load("lw_10_kept", 32'h10, 3'b010, 1'b0, 32'h80223344);

        // Strobe while busy is dropped: only one response expected.
        load("lw_busy", 32'h10, 3'b010, 1'b0, 32'h80223344);
        bus.mem_read = 1'b1;
        bus.addr     = 32'h14;
        bus.func3    = 3'b010;
        @(posedge clk);
        #1 bus.mem_read = 1'b0;
        wait_ready();
        repeat (3) @(negedge clk);

        // Reset mid-store aborts the commit.
        store("sw_20_zero", 32'h20, 32'h0, 3'b010, 1'b0);
        issue("sw_20_abort", 1'b0, 1'b1, 32'h20, 32'h55, 3'b010, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        chk("abort_valid", {31'd0, bus.valid}, 32'd0);
`ifdef DMEM_ACCESS_CNT_EN
        chk("abort_wr_count", {16'd0, wr_count}, 32'd0);
`endif
        load("lw_20_after", 32'h20, 3'b010, 1'b0, 32'h00000000);

        // Halfword store to the upper lanes.
        store("sh_22", 32'h22, 32'h1234BEEF, 3'b001, 1'b0);
        load("lw_20_sh", 32'h20, 3'b010, 1'b0, 32'hBEEF0000);

        // Address aliasing across the 256-word array.
        store("sw_400", 32'h400, 32'hA5A5A5A5, 3'b010, 1'b0);
        load("lw_000", 32'h000, 3'b010, 1'b0, 32'hA5A5A5A5);

        wait_ready();
        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the memory end of the load/store path: consumes the controller's mem_read/mem_write strobes plus ALU address, rs2 data and funct3.
- Serves byte/half/word loads and stores with a fixed, parameterised latency and a ready/valid handshake.
- Sits between the datapath's memory stage and the word-organised data RAM; the multi-cycle-capable core stalls on ready/valid.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two, >=4).
- LATENCY, 2, cycles from acceptance to response (1..15).

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- addr  in  32  byte address.
- wdata  in  32  store data; low byte/half used for sb/sh.
- func3  in  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu; others illegal.
- ready  out  1  responder idle, request accepted this cycle if strobed.
- busy  out  1  request outstanding (equals ~ready outside reset).
- valid  out  1  one-cycle response pulse.
- rdata  out  32  extended load data, valid only with valid=1 on a good load.
- err  out  1  qualified by valid: access was illegal and had no effect.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, ready=1, busy=0, valid=0, rdata=0, err=0, latency counter=0. Array contents are not cleared. Reset mid-operation aborts the request; a pending store is never committed.
- States:
  - IDLE: ready=1.
  - WAIT: counter counts down.
  - RESP: valid=1 for exactly one cycle, then back to IDLE.
- Acceptance: in IDLE with mem_read|mem_write=1. Latch addr, wdata, func3, op, and the error flag. Go to WAIT with counter=LATENCY-1; if LATENCY=1, go directly to RESP.
- Response timing: acceptance at cycle T gives valid=1 at T+LATENCY.
- ready=0 from T+1 through T+LATENCY inclusive. Strobes while not ready are ignored, not queued.
- RESP cannot accept; next acceptance is at T+LATENCY+1 at the earliest.
- Error conditions (err=1, no array access, rdata=0), checked at acceptance:
  - mem_read and mem_write both 1.
  - func3 illegal for the op: sb/sh/sw use only 000/001/010.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- Word index = addr[clog2(DEPTH_WORDS)+1:2]; upper address bits ignored (wrap-around aliasing).
- Store commit happens at the RESP edge. Byte-lane write enables come from addr[1:0]: b writes lane addr[1:0]; h writes lanes {addr[1],0} and {addr[1],1}; w writes all 4. Other lanes are unchanged.
- Load data:
  - Read at RESP and presented combinationally from the registered word.
  - Lane selected by addr[1:0].
  - b/h sign-extended; bu/hu zero-extended.
  - rdata is held from the last good load until the next response.
- Stores: rdata=0 during valid.
- Little-endian: byte 0 = bits 7:0.

Optional Feature:
- Macro DMEM_ACCESS_CNT_EN.
- When defined: adds outputs rd_count[15:0] and wr_count[15:0]. Each increments by 1 in the RESP cycle of a good load/store (err=0), wraps 0xFFFF->0, and resets to 0 on rst.
- When undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- LATENCY=2, sw addr=0x10 wdata=0xDEADBEEF accepted at T -> ready=0 at T+1,T+2; valid=1,err=0 at T+2 only. Then lw 0x10 -> rdata=0xDEADBEEF, err=0.
- sb wdata=0x00000080 to 0x13 over word 0x11223344 at 0x10 -> lw 0x10 returns 0x80223344; lb 0x13 returns 0xFFFFFF80; lbu 0x13 returns 0x00000080; lh 0x12 returns 0xFFFF8022.
- lh addr=0x11, or sw addr=0x12 -> valid at T+2 with err=1, rdata=0; following lw shows memory unchanged.
- mem_read=mem_write=1 -> err=1. mem_read strobed at T+1 while busy -> ignored, no second valid.
- sw 0x55 to 0x20 (old 0x0) with rst=1 at T+1 -> ready=1, valid=0 after reset; lw 0x20 returns 0x00000000. Under DMEM_ACCESS_CNT_EN, wr_count=0.
- DEPTH_WORDS=256: sw 0xA5A5A5A5 to 0x400 -> lw 0x000 returns 0xA5A5A5A5 (aliasing).
